// File: rtl/display_scan_ctrl.sv
// Scan controller for a 6-digit multiplexed 7-segment clock display.
// Each slot: one SELECT clock, then N lit ticks, then DWELL_TICKS-N dark ticks.
module display_scan_ctrl #(
    parameter int DWELL_TICKS = 8,
    parameter int BLANK_TICKS = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_tick,
    input  logic [2:0] i_brightness,
    input  logic       i_lz_blank,
    input  logic [3:0] i_bcd,
    input  logic       i_dp,
    output logic [2:0] o_seg_select,
    output logic [5:0] o_digit_en,
    output logic [3:0] o_bcd,
    output logic       o_dp,
    output logic       o_frame_stb,
    output logic [1:0] o_dbg_state
);
    localparam int CW = 5;
    localparam logic [CW-1:0] DWELL_W  = CW'(DWELL_TICKS);
    localparam logic [CW-1:0] MAX_ON_W = CW'(DWELL_TICKS - BLANK_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ON     = 2'd2,
        S_BLANK  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] blank_q, blank_d;
    logic [2:0]    seg_q, seg_d;
    logic [5:0]    en_q, en_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dp_q, dp_d;
    logic          stb_q, stb_d;
    logic [CW-1:0] req_ticks;
    logic [CW-1:0] on_ticks;
    logic          lz_hide;

    assign req_ticks = {2'b00, i_brightness} + 5'd1;
    assign on_ticks  = (req_ticks > MAX_ON_W) ? MAX_ON_W : req_ticks;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            blank_q <= '0;
            seg_q   <= '0;
            en_q    <= '0;
            bcd_q   <= '0;
            dp_q    <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        seg_d   = (seg_q > 3'd5) ? 3'd0 : seg_q;
        bcd_d   = bcd_q;
        dp_d    = dp_q;
        stb_d   = 1'b0;
        if (!i_enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            seg_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SELECT;
                    seg_d   = 3'd0;
                end
                S_SELECT: begin
                    bcd_d   = i_bcd;
                    dp_d    = i_dp;
                    cnt_d   = on_ticks;
                    blank_d = DWELL_W - on_ticks;
                    state_d = S_ON;
                end
                S_ON: begin
                    if (i_tick) begin
                        if (cnt_q <= CW'(1)) begin
                            state_d = S_BLANK;
                            cnt_d   = blank_q;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    if (i_tick) begin
                        if (cnt_q <= CW'(1)) begin
                            state_d = S_SELECT;
                            cnt_d   = '0;
                            seg_d   = (seg_q >= 3'd5) ? 3'd0 : seg_q + 3'd1;
                            stb_d   = (seg_q == 3'd5);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // A blank hours MSD keeps its slot timing; only the driver stays off.
    assign lz_hide = i_lz_blank && (seg_d == 3'd0) && (bcd_d == 4'd0) && !dp_d;

    always_comb begin
        en_d = '0;
        if (state_d == S_ON && !lz_hide) begin
            en_d = 6'd1 << seg_d;
        end
    end

    assign o_seg_select = seg_q;
    assign o_digit_en   = en_q;
    assign o_bcd        = bcd_q;
    assign o_dp         = dp_q;
    assign o_frame_stb  = stb_q;
    assign o_dbg_state  = state_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: per-scenario table of expected slot
// timing and captured digits, plus disable and async-reset sequences.
module tb_display_scan_ctrl;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_SEL = 2'd1, ST_ON = 2'd2, ST_BLANK = 2'd3;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_tick = 1'b0;
    logic [2:0] i_brightness = 3'd7;
    logic       i_lz_blank = 1'b0;
    logic [3:0] i_bcd;
    logic       i_dp;
    logic [2:0] o_seg_select;
    logic [5:0] o_digit_en;
    logic [3:0] o_bcd;
    logic       o_dp;
    logic       o_frame_stb;
    logic [1:0] o_dbg_state;

    display_scan_ctrl #(.DWELL_TICKS(8), .BLANK_TICKS(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_tick(i_tick),
        .i_brightness(i_brightness), .i_lz_blank(i_lz_blank), .i_bcd(i_bcd), .i_dp(i_dp),
        .o_seg_select(o_seg_select), .o_digit_en(o_digit_en), .o_bcd(o_bcd), .o_dp(o_dp),
        .o_frame_stb(o_frame_stb), .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    // Clock-to-BCD mux model; dp mask MSB belongs to digit 0.
    int hh = 0, mm = 0, ss = 0;
    logic [5:0] dpm = '0;
    always_comb begin
        case (o_seg_select)
            3'd0:    i_bcd = 4'(hh / 10);
            3'd1:    i_bcd = 4'(hh % 10);
            3'd2:    i_bcd = 4'(mm / 10);
            3'd3:    i_bcd = 4'(mm % 10);
            3'd4:    i_bcd = 4'(ss / 10);
            3'd5:    i_bcd = 4'(ss % 10);
            default: i_bcd = 4'd0;
        endcase
        i_dp = (o_seg_select <= 3'd5) ? dpm[3'd5 - o_seg_select] : 1'b0;
    end

    int n_chk = 0, n_pass = 0;
    int tick_per = 1, tick_cnt = 0;
    int nslot, slot_clks, on_t, blank_t, en_viol, stb_cnt, stb_viol;
    logic slot_lit;
    int r_seg[6], r_on[6], r_blank[6], r_clks[6], r_bcd[6], r_dp[6], r_lit[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clear_mon();
        nslot = 0; slot_clks = 0; on_t = 0; blank_t = 0; slot_lit = 1'b0;
        en_viol = 0; stb_cnt = 0; stb_viol = 0;
        for (int k = 0; k < 6; k++) begin
            r_seg[k] = -1; r_on[k] = -1; r_blank[k] = -1; r_clks[k] = -1;
            r_bcd[k] = -1; r_dp[k] = -1; r_lit[k] = -1;
        end
    endtask

    // One clock: drive the tick, step, then account the slot from outputs.
    task automatic cyc();
        logic [1:0] st_b;
        logic       tk_b;
        logic [2:0] seg_b;
        i_tick = ((tick_cnt % tick_per) == 0);
        tick_cnt++;
        st_b = o_dbg_state; tk_b = i_tick; seg_b = o_seg_select;
        @(posedge i_clk);
        #1;
        if (st_b != ST_IDLE) slot_clks++;
        if (tk_b && st_b == ST_ON) on_t++;
        if (tk_b && st_b == ST_BLANK) blank_t++;
        if (o_digit_en != 6'd0) begin
            slot_lit = 1'b1;
            if (o_dbg_state != ST_ON || o_digit_en != (6'd1 << o_seg_select)) en_viol++;
        end
        if (o_frame_stb) begin
            stb_cnt++;
            if (o_seg_select != 3'd0 || o_dbg_state != ST_SEL) stb_viol++;
        end
        if (st_b == ST_BLANK && o_seg_select != seg_b && nslot < 6) begin
            r_seg[nslot] = int'(seg_b); r_on[nslot] = on_t; r_blank[nslot] = blank_t;
            r_clks[nslot] = slot_clks; r_bcd[nslot] = int'(o_bcd); r_dp[nslot] = int'(o_dp);
            r_lit[nslot] = int'(slot_lit);
            nslot++;
            slot_clks = 0; on_t = 0; blank_t = 0; slot_lit = 1'b0;
        end
    endtask

    typedef struct {
        int         per;
        logic [2:0] b;
        int         chg_cycle;
        logic [2:0] chg_b;
        logic       lz;
        int         h, m, s;
        logic [5:0] dmask;
        logic [23:0] e_on, e_blank, e_bcd;   // nibble per digit, digit 0 leftmost
        logic [5:0] e_dp, e_lit;             // bit k = digit k
        int         e_clks;                  // 0: slot length varies with tick phase
    } scen_t;

    scen_t sc[7];

    function automatic int nib(input logic [23:0] v, input int k);
        return int'(v[(5 - k) * 4 +: 4]);
    endfunction

    task automatic start_run(input int per, input logic [2:0] b, input logic lz,
                             input int h, input int m, input int s, input logic [5:0] dmask);
        i_enable = 1'b0;
        cyc(); cyc();
        hh = h; mm = m; ss = s; dpm = dmask;
        i_brightness = b; i_lz_blank = lz; tick_per = per; tick_cnt = 0;
        clear_mon();
        i_enable = 1'b1;
    endtask

    initial begin
        sc[0] = '{4, 3'd7, -1, 3'd0, 1'b0, 9, 45, 7, 6'b000100, 24'h777777, 24'h111111, 24'h094507, 6'b001000, 6'b111111, 0};
        sc[1] = '{4, 3'd0, -1, 3'd0, 1'b0, 9, 45, 7, 6'b000100, 24'h111111, 24'h777777, 24'h094507, 6'b001000, 6'b111111, 0};
        sc[2] = '{1, 3'd3, -1, 3'd0, 1'b0, 9, 45, 7, 6'b000000, 24'h444444, 24'h444444, 24'h094507, 6'b000000, 6'b111111, 9};
        sc[3] = '{1, 3'd7, 3, 3'd3, 1'b0, 9, 45, 7, 6'b000000, 24'h744444, 24'h144444, 24'h094507, 6'b000000, 6'b111111, 9};
        sc[4] = '{2, 3'd7, -1, 3'd0, 1'b1, 9, 45, 7, 6'b000000, 24'h777777, 24'h111111, 24'h094507, 6'b000000, 6'b111110, 0};
        sc[5] = '{2, 3'd7, -1, 3'd0, 1'b1, 12, 30, 59, 6'b000000, 24'h777777, 24'h111111, 24'h123059, 6'b000000, 6'b111111, 0};
        sc[6] = '{1, 3'd7, -1, 3'd0, 1'b1, 9, 45, 7, 6'b100000, 24'h777777, 24'h111111, 24'h094507, 6'b000001, 6'b111111, 9};

        // Reset values, checked before any clock edge.
        #1 i_reset = 1'b1;
        #1;
        chk("rst_seg", int'(o_seg_select), 0);
        chk("rst_en", int'(o_digit_en), 0);
        chk("rst_bcd", int'(o_bcd), 0);
        chk("rst_dp", int'(o_dp), 0);
        chk("rst_stb", int'(o_frame_stb), 0);
        chk("rst_state", int'(o_dbg_state), int'(ST_IDLE));
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        clear_mon();
        cyc();
        chk("idle_hold_state", int'(o_dbg_state), int'(ST_IDLE));

        for (int si = 0; si < 7; si++) begin
            start_run(sc[si].per, sc[si].b, sc[si].lz, sc[si].h, sc[si].m, sc[si].s, sc[si].dmask);
            for (int i = 0; i < 1000 && nslot < 6; i++) begin
                if (i == sc[si].chg_cycle) i_brightness = sc[si].chg_b;
                cyc();
            end
            chk($sformatf("s%0d_slots_done", si), nslot, 6);
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("s%0d_d%0d_seg", si, k), r_seg[k], k);
                chk($sformatf("s%0d_d%0d_on", si, k), r_on[k], nib(sc[si].e_on, k));
                chk($sformatf("s%0d_d%0d_blank", si, k), r_blank[k], nib(sc[si].e_blank, k));
                chk($sformatf("s%0d_d%0d_bcd", si, k), r_bcd[k], nib(sc[si].e_bcd, k));
                chk($sformatf("s%0d_d%0d_dp", si, k), r_dp[k], int'(sc[si].e_dp[k]));
                chk($sformatf("s%0d_d%0d_lit", si, k), r_lit[k], int'(sc[si].e_lit[k]));
                if (sc[si].e_clks != 0)
                    chk($sformatf("s%0d_d%0d_clks", si, k), r_clks[k], sc[si].e_clks);
            end
            chk($sformatf("s%0d_stb_count", si), stb_cnt, 1);
            chk($sformatf("s%0d_stb_where", si), stb_viol, 0);
            chk($sformatf("s%0d_en_onehot", si), en_viol, 0);
        end

        // Disable while digit 3 is lit, then re-enable.
        start_run(1, 3'd7, 1'b0, 9, 45, 7, 6'b000000);
        for (int i = 0; i < 200 && !(o_seg_select == 3'd3 && o_dbg_state == ST_ON); i++) cyc();
        chk("dis_reach_d3_on", int'(o_dbg_state == ST_ON && o_seg_select == 3'd3), 1);
        cyc();
        i_enable = 1'b0;
        cyc();
        chk("dis_en", int'(o_digit_en), 0);
        chk("dis_seg", int'(o_seg_select), 0);
        chk("dis_state", int'(o_dbg_state), int'(ST_IDLE));
        chk("dis_bcd_hold", int'(o_bcd), 5);
        chk("dis_no_stb", int'(o_frame_stb), 0);
        i_enable = 1'b1;
        cyc();
        chk("reen_state", int'(o_dbg_state), int'(ST_SEL));
        chk("reen_seg", int'(o_seg_select), 0);
        cyc();
        chk("reen_en", int'(o_digit_en), 1);
        chk("reen_bcd", int'(o_bcd), 0);

        // Async reset while blanking: outputs clear between clock edges.
        for (int i = 0; i < 200 && o_dbg_state != ST_BLANK; i++) cyc();
        chk("ar_reach_blank", int'(o_dbg_state), int'(ST_BLANK));
        #2 i_reset = 1'b1;
        #1;
        chk("ar_state", int'(o_dbg_state), int'(ST_IDLE));
        chk("ar_seg", int'(o_seg_select), 0);
        chk("ar_bcd", int'(o_bcd), 0);
        chk("ar_en", int'(o_digit_en), 0);
        #2 i_reset = 1'b0;
        cyc();
        chk("ar_restart_state", int'(o_dbg_state), int'(ST_SEL));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
